ibox_pipe: RTL

//  Registered, parametrised integer execute unit for the Alpha-style integer datapath.

---
 rtl/ibox_pipe.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ibox_pipe.sv
// Integer execute unit: single-cycle ALU ops plus an iterative shift-add
// multiplier, with a valid/ready result register between issue and writeback.
module ibox_pipe #(
    parameter int XLEN     = 64,
    parameter int MUL_STEP = 4,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic             in_lw,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int SH_W  = $clog2(XLEN);
    localparam int NB    = XLEN / 8;
    localparam int NSTEP = XLEN / MUL_STEP;
    localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSTEP - 1);

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_AND    = 4'd2;
    localparam logic [3:0] OP_BIC    = 4'd3;
    localparam logic [3:0] OP_BIS    = 4'd4;
    localparam logic [3:0] OP_XOR    = 4'd5;
    localparam logic [3:0] OP_SLL    = 4'd6;
    localparam logic [3:0] OP_SRL    = 4'd7;
    localparam logic [3:0] OP_SRA    = 4'd8;
    localparam logic [3:0] OP_CMPEQ  = 4'd9;
    localparam logic [3:0] OP_CMPLT  = 4'd10;
    localparam logic [3:0] OP_CMPULT = 4'd11;
    localparam logic [3:0] OP_CMPBGE = 4'd12;
    localparam logic [3:0] OP_ZAP    = 4'd13;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_valid;
    logic [XLEN-1:0]     r_result;
    logic [TAG_W-1:0]    r_tag;
    logic [2*XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]     r_mplier;
    logic [2*XLEN-1:0]   r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_mhi;
    logic                r_mlw;
    logic [TAG_W-1:0]    r_mtag;

    logic                w_accept;
    logic                w_is_mul;
    logic                w_mul_done;
    logic [SH_W-1:0]     w_shamt;
    logic [XLEN-1:0]     w_addsub;
    logic [XLEN-1:0]     w_alu;
    logic [2*XLEN-1:0]   w_pp;
    logic [2*XLEN-1:0]   w_acc_nxt;
    logic [XLEN-1:0]     w_mul_res;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        sext32 = XLEN'($signed(v));
    endfunction

    assign in_ready   = (r_state == S_IDLE) & (!r_valid | out_ready) & !flush;
    assign w_accept   = in_valid & in_ready;
    assign w_is_mul   = (in_op[3:1] == 3'b111);
    assign w_mul_done = (r_state == S_MUL) & (r_cnt == LAST) & !flush;
    assign w_shamt    = in_b[SH_W-1:0];
    assign w_addsub   = (in_op == OP_SUB) ? in_a - in_b : in_a + in_b;

    assign out_valid  = r_valid;
    assign out_result = r_result;
    assign out_tag    = r_tag;
    assign busy       = (r_state == S_MUL);

    always_comb begin
        w_alu = '0;
        unique case (in_op)
            OP_ADD, OP_SUB: w_alu = in_lw ? sext32(w_addsub[31:0]) : w_addsub;
            OP_AND:    w_alu = in_a & in_b;
            OP_BIC:    w_alu = in_a & ~in_b;
            OP_BIS:    w_alu = in_a | in_b;
            OP_XOR:    w_alu = in_a ^ in_b;
            OP_SLL:    w_alu = in_a << w_shamt;
            OP_SRL:    w_alu = in_a >> w_shamt;
            OP_SRA:    w_alu = $signed(in_a) >>> w_shamt;
            OP_CMPEQ:  w_alu[0] = (in_a == in_b);
            OP_CMPLT:  w_alu[0] = ($signed(in_a) < $signed(in_b));
            OP_CMPULT: w_alu[0] = (in_a < in_b);
            OP_CMPBGE: begin
                for (int i = 0; i < NB; i++)
                    w_alu[i] = (in_a[8*i +: 8] >= in_b[8*i +: 8]);
            end
            OP_ZAP: begin
                for (int i = 0; i < NB; i++)
                    w_alu[8*i +: 8] = in_b[i] ? 8'h00 : in_a[8*i +: 8];
            end
            default:   w_alu = '0;
        endcase
    end

    // Multiplicand is pre-shifted each step, so bit j of the multiplier
    // always weights r_mcand << j.
    always_comb begin
        w_pp = '0;
        for (int j = 0; j < MUL_STEP; j++)
            if (r_mplier[j])
                w_pp = w_pp + (r_mcand << j);
    end

    assign w_acc_nxt = r_acc + w_pp;

    always_comb begin
        if (r_mhi)
            w_mul_res = w_acc_nxt[2*XLEN-1:XLEN];
        else if (r_mlw)
            w_mul_res = sext32(w_acc_nxt[31:0]);
        else
            w_mul_res = w_acc_nxt[XLEN-1:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept && w_is_mul) w_state_nxt = S_MUL;
            S_MUL:  if (r_cnt == LAST) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush)
            w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mhi    <= 1'b0;
            r_mlw    <= 1'b0;
            r_mtag   <= '0;
        end else if (flush) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept && w_is_mul) begin
            r_mcand  <= {{XLEN{1'b0}}, in_a};
            r_mplier <= in_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mhi    <= in_op[0];
            r_mlw    <= in_lw;
            r_mtag   <= in_tag;
        end else if (r_state == S_MUL) begin
            r_mcand  <= r_mcand << MUL_STEP;
            r_mplier <= r_mplier >> MUL_STEP;
            r_acc    <= w_acc_nxt;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_tag    <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_valid  <= 1'b1;
            r_result <= w_alu;
            r_tag    <= in_tag;
        end else if (w_mul_done) begin
            r_valid  <= 1'b1;
            r_result <= w_mul_res;
            r_tag    <= r_mtag;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
